fe_queue_stage: RTL and testbench
=================================

FE_QUEUE_STAGE -- requirements
Module: fe_queue_stage

Interface
REQ-001 Parameter DBITS, 32, data/PC width.
REQ-002 Parameter INSTBITS, 32, instruction width.
REQ-003 Parameter QDEPTH, 4, fetch-queue entries; power of two, >=2.
REQ-004 Parameter IMEMWORDS, 16384, instruction-memory words (4 B each).
REQ-005 Parameter STARTPC, 32'h0000_0100, PC loaded on reset.
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 reset  in  1  asynchronous, active-high.
REQ-008 redirect_valid  in  1  flush plus PC redirect (branch resolve/mispredict).
REQ-009 redirect_pc  in  DBITS  redirect target.
REQ-010 bp_next_pc  in  DBITS  predicted next PC for fe_pc, from predictor.
REQ-011 fe_pc  out  DBITS  current fetch PC, to predictor.
REQ-012 de_ready  in  1  decode accepts head entry this cycle.
REQ-013 out_valid  out  1  head entry valid.
REQ-014 out_inst, out_pc, out_npc  out  INSTBITS/DBITS/DBITS  head instruction, its PC, its predicted next PC.
REQ-015 q_count  out  $clog2(QDEPTH)+1  occupied entries.

Function
REQ-016 Instruction read combinational: imem[fe_pc[$clog2(IMEMWORDS)+1:2]]; fe_pc bits [1:0] ignored.
REQ-017 push = !redirect_valid && (q_count<QDEPTH || pop); pop = out_valid && de_ready.
REQ-018 On push: write {inst, fe_pc, bp_next_pc} at tail; fe_pc <= bp_next_pc; tail wraps modulo QDEPTH.
REQ-019 No push: fe_pc holds.
REQ-020 On pop: head advances modulo QDEPTH; q_count -1.
REQ-021 Simultaneous push/pop: q_count unchanged, legal at full and at empty (empty: only push takes effect, pop is 0).
REQ-022 out_valid = (q_count!=0); out_* driven from head entry, registered storage, no combinational bypass from fetch.
REQ-023 Latency: PC fetched into empty queue at edge N presents out_valid in the cycle after edge N.
REQ-024 redirect_valid priority over push and pop: next edge clears head, tail, q_count to 0, fe_pc <= redirect_pc; out_* contents beyond valid are don't-care.
REQ-025 First redirected instruction: out_valid high after second rising edge following redirect sample.
REQ-026 de_ready while out_valid=0: no effect.
REQ-027 Entries not valid (index outside head..tail) never drive out_valid.

Reset
REQ-028 Asynchronous assert: fe_pc=STARTPC, head=tail=0, q_count=0, out_valid=0 immediately, no clock needed.
REQ-029 Reset mid-operation discards all queued entries; queue storage RAM not cleared.
REQ-030 First push on first rising edge after reset deassertion.

Configuration
REQ-031 Macro FE_QUEUE_INST_COUNT_EN defined: extra output out_count (DBITS) carried per entry; fetch counter starts at 1 on reset, +1 per push, not reset by redirect.
REQ-032 Macro undefined: out_count port, counter and per-entry field absent; all other behaviour identical.

Structure
REQ-033 Shared package/header fe_pkg: entry field widths, STARTPC default, canary constant, fetch-entry bundle layout {inst, pc, npc[, count]}.
REQ-034 One sub-module fe_fifo (parametrised width/depth circular buffer: push, pop, flush, count); fetch PC logic and imem stay in top.

Verification
REQ-035 Reset, de_ready=1, bp_next_pc=fe_pc+4: out_pc sequence 0x100,0x104,0x108 on consecutive cycles; first out_valid one cycle after deassert.
REQ-036 de_ready=0 for 6 cycles, QDEPTH=4: q_count saturates at 4, fe_pc holds 0x110, no overwrite; then de_ready=1 yields 0x100..0x10C in order.
REQ-037 Full queue, de_ready=1 continuously: push+pop each cycle, q_count stays 4, no bubble.
REQ-038 redirect_valid=1, redirect_pc=0x400 with 3 entries queued: next cycle q_count=0, out_valid=0; out_pc=0x400 valid two edges after redirect.
REQ-039 Redirect and de_ready both high on full queue: redirect wins, no entry delivered or pushed.
REQ-040 Async reset pulsed mid-cycle with 2 entries queued: out_valid=0 and fe_pc=0x100 before next clock edge; with FE_QUEUE_INST_COUNT_EN, first out_count=1.

Source files
------------

// File: rtl/fe_pkg.sv
// Shared fetch-stage definitions: entry widths, reset PC, canary and the fetch-entry bundle.
// Optional per-entry fetch counter is enabled by FE_QUEUE_INST_COUNT_EN.
package fe_pkg;

  localparam int unsigned FE_DBITS    = 32;
  localparam int unsigned FE_INSTBITS = 32;
  localparam logic [31:0] FE_STARTPC  = 32'h0000_0100;
  localparam logic [31:0] FE_CANARY   = 32'hDEAD_BEEF;

  // Bundle order {inst, pc, npc[, count]} matches the packed FIFO word in fe_queue_stage.
  typedef struct packed {
    logic [FE_INSTBITS-1:0] inst;
    logic [FE_DBITS-1:0]    pc;
    logic [FE_DBITS-1:0]    npc;
`ifdef FE_QUEUE_INST_COUNT_EN
    logic [FE_DBITS-1:0]    count;
`endif
  } fe_entry_t;

  function automatic int unsigned fe_entry_bits(int unsigned inst_bits, int unsigned data_bits);
`ifdef FE_QUEUE_INST_COUNT_EN
    return inst_bits + 3 * data_bits;
`else
    return inst_bits + 2 * data_bits;
`endif
  endfunction

endpackage

// File: rtl/fe_fifo.sv
// Parametrised circular buffer with push, pop, synchronous flush and occupancy count.
module fe_fifo #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count
);
  import fe_pkg::*;

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic             pop_eff;
  logic             push_eff;

  assign valid    = (count != '0);
  assign pop_eff  = pop && valid && !flush;
  assign push_eff = push && !flush && ((count < CW'(DEPTH)) || pop_eff);
  assign rdata    = mem[head];

  // Storage is a plain RAM: reset and flush only move the pointers.
  always_ff @(posedge clk) begin
    if (push_eff) mem[tail] <= wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_eff) tail <= tail + PW'(1);
      if (pop_eff)  head <= head + PW'(1);
      if (push_eff && !pop_eff)      count <= count + CW'(1);
      else if (pop_eff && !push_eff) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/fe_queue_stage.sv
// Fetch stage: PC register, combinational imem read and a fetch queue feeding decode.
// Define FE_QUEUE_INST_COUNT_EN to carry a running fetch count with every entry.
module fe_queue_stage
  import fe_pkg::*;
#(
  parameter int unsigned       DBITS     = 32,
  parameter int unsigned       INSTBITS  = 32,
  parameter int unsigned       QDEPTH    = 4,
  parameter int unsigned       IMEMWORDS = 16384,
  parameter logic [DBITS-1:0]  STARTPC   = FE_STARTPC
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          redirect_valid,
  input  logic [DBITS-1:0]              redirect_pc,
  input  logic [DBITS-1:0]              bp_next_pc,
  output logic [DBITS-1:0]              fe_pc,
  input  logic                          de_ready,
  output logic                          out_valid,
  output logic [INSTBITS-1:0]           out_inst,
  output logic [DBITS-1:0]              out_pc,
  output logic [DBITS-1:0]              out_npc,
`ifdef FE_QUEUE_INST_COUNT_EN
  output logic [DBITS-1:0]              out_count,
`endif
  output logic [$clog2(QDEPTH):0]       q_count,
  // imem load port
  input  logic                          imem_we,
  input  logic [$clog2(IMEMWORDS)-1:0]  imem_waddr,
  input  logic [INSTBITS-1:0]           imem_wdata
);

  localparam int unsigned AW = $clog2(IMEMWORDS);
  localparam int unsigned CW = $clog2(QDEPTH) + 1;
  localparam int unsigned EW = fe_entry_bits(INSTBITS, DBITS);

  logic [INSTBITS-1:0] imem [IMEMWORDS];
  logic [INSTBITS-1:0] fetch_inst;
  logic [EW-1:0]       push_entry;
  logic [EW-1:0]       head_entry;
  logic                push;
  logic                pop;
  logic                unused_pc_bits;

  always_ff @(posedge clk) begin
    if (imem_we) imem[imem_waddr] <= imem_wdata;
  end

  assign fetch_inst     = imem[fe_pc[AW+1:2]];
  assign unused_pc_bits = ^{fe_pc[1:0], fe_pc[DBITS-1:AW+2]};

  assign pop  = out_valid && de_ready;
  assign push = !redirect_valid && ((q_count < CW'(QDEPTH)) || pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               fe_pc <= STARTPC;
    else if (redirect_valid) fe_pc <= redirect_pc;
    else if (push)           fe_pc <= bp_next_pc;
  end

`ifdef FE_QUEUE_INST_COUNT_EN
  logic [DBITS-1:0] inst_cnt;

  // Counts every fetch since reset; redirects deliberately do not restart it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     inst_cnt <= DBITS'(1);
    else if (push) inst_cnt <= inst_cnt + DBITS'(1);
  end

  assign push_entry = {fetch_inst, fe_pc, bp_next_pc, inst_cnt};
  assign {out_inst, out_pc, out_npc, out_count} = head_entry;
`else
  assign push_entry = {fetch_inst, fe_pc, bp_next_pc};
  assign {out_inst, out_pc, out_npc} = head_entry;
`endif

  fe_fifo #(
    .WIDTH (EW),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head_entry),
    .valid (out_valid),
    .count (q_count)
  );

endmodule

// File: tb/tb_fe_queue_stage.sv
// Bench for fe_queue_stage: directed table, reset corner cases and random traffic vs a queue model.
module tb_fe_queue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] bp_next_pc;
  logic [31:0] fe_pc;
  logic        de_ready;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_npc;
  logic [2:0]  q_count;
  logic        imem_we;
  logic [13:0] imem_waddr;
  logic [31:0] imem_wdata;
`ifdef FE_QUEUE_INST_COUNT_EN
  logic [31:0] out_count;
`endif

  logic        use_rand_bp;
  logic [31:0] rand_bp;
  int          n_chk = 0;
  int          n_fail = 0;

  assign bp_next_pc = use_rand_bp ? rand_bp : fe_pc + 32'd4;

  always #5 clk = ~clk;

  fe_queue_stage dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bp_next_pc     (bp_next_pc),
    .fe_pc          (fe_pc),
    .de_ready       (de_ready),
    .out_valid      (out_valid),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_npc        (out_npc),
`ifdef FE_QUEUE_INST_COUNT_EN
    .out_count      (out_count),
`endif
    .q_count        (q_count),
    .imem_we        (imem_we),
    .imem_waddr     (imem_waddr),
    .imem_wdata     (imem_wdata)
  );

  function automatic logic [31:0] inst_of(logic [31:0] pc);
    logic [13:0] w;
    w = pc[15:2];
    return {2'b10, w, ~w, 2'b01};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        de_ready;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_valid;
    logic [2:0]  exp_q;
    logic [31:0] exp_out_pc;
    logic [31:0] exp_fe;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] cnt;
  } ent_t;

  vec_t        tbl[13];
  ent_t        mq[$];
  ent_t        e;
  logic [31:0] mpc;
  logic [31:0] mcnt;
  logic        mpop;
  logic        mpush;

  initial begin
    // Fill, saturate, drain with continuous push+pop, redirect on a full queue, refill.
    tbl[0]  = '{1'b0, 1'b0, 32'h0, 1'b1, 3'd1, 32'h100, 32'h104};
    tbl[1]  = '{1'b0, 1'b0, 32'h0, 1'b1, 3'd2, 32'h100, 32'h108};
    tbl[2]  = '{1'b0, 1'b0, 32'h0, 1'b1, 3'd3, 32'h100, 32'h10C};
    tbl[3]  = '{1'b0, 1'b0, 32'h0, 1'b1, 3'd4, 32'h100, 32'h110};
    tbl[4]  = '{1'b0, 1'b0, 32'h0, 1'b1, 3'd4, 32'h100, 32'h110};
    tbl[5]  = '{1'b0, 1'b0, 32'h0, 1'b1, 3'd4, 32'h100, 32'h110};
    tbl[6]  = '{1'b1, 1'b0, 32'h0, 1'b1, 3'd4, 32'h104, 32'h114};
    tbl[7]  = '{1'b1, 1'b0, 32'h0, 1'b1, 3'd4, 32'h108, 32'h118};
    tbl[8]  = '{1'b1, 1'b0, 32'h0, 1'b1, 3'd4, 32'h10C, 32'h11C};
    tbl[9]  = '{1'b1, 1'b0, 32'h0, 1'b1, 3'd4, 32'h110, 32'h120};
    tbl[10] = '{1'b1, 1'b1, 32'h400, 1'b0, 3'd0, 32'h0, 32'h400};
    tbl[11] = '{1'b1, 1'b0, 32'h0, 1'b1, 3'd1, 32'h400, 32'h404};
    tbl[12] = '{1'b1, 1'b0, 32'h0, 1'b1, 3'd1, 32'h404, 32'h408};

    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    de_ready = 1'b0;
    use_rand_bp = 1'b0;
    rand_bp = '0;
    imem_we = 1'b0;
    imem_waddr = '0;
    imem_wdata = '0;

    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      imem_we = 1'b1;
      imem_waddr = 14'(i);
      imem_wdata = inst_of(32'(i) << 2);
    end
    @(negedge clk);
    imem_we = 1'b0;
    reset = 1'b0;
    #1;
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_qcount", 32'(q_count), 32'd0);
    chk("reset_fe_pc", fe_pc, 32'h100);
    #1;

    for (int i = 0; i < 13; i++) begin
      de_ready = tbl[i].de_ready;
      redirect_valid = tbl[i].redir;
      redirect_pc = tbl[i].rpc;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_qcount", i), 32'(q_count), 32'(tbl[i].exp_q));
      chk($sformatf("tbl%0d_fe_pc", i), fe_pc, tbl[i].exp_fe);
      if (tbl[i].exp_valid) begin
        chk($sformatf("tbl%0d_out_pc", i), out_pc, tbl[i].exp_out_pc);
        chk($sformatf("tbl%0d_out_npc", i), out_npc, tbl[i].exp_out_pc + 32'd4);
        chk($sformatf("tbl%0d_out_inst", i), out_inst, inst_of(tbl[i].exp_out_pc));
      end
    end
    redirect_valid = 1'b0;

    // Asynchronous reset pulsed mid-cycle with two entries queued.
    de_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("pre_areset_qcount", 32'(q_count), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("areset_valid", 32'(out_valid), 32'd0);
    chk("areset_fe_pc", fe_pc, 32'h100);
    chk("areset_qcount", 32'(q_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    de_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_areset_valid", 32'(out_valid), 32'd1);
    chk("post_areset_out_pc", out_pc, 32'h100);
`ifdef FE_QUEUE_INST_COUNT_EN
    chk("post_areset_count", out_count, 32'd1);
`endif

    // Random traffic against the queue model.
    reset = 1'b1;
    de_ready = 1'b0;
    redirect_valid = 1'b0;
    use_rand_bp = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mq.delete();
    mpc = 32'h100;
    mcnt = 32'd1;
    for (int i = 0; i < 400; i++) begin
      chk("rnd_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("rnd_qcount", 32'(q_count), 32'(mq.size()));
      chk("rnd_fe_pc", fe_pc, mpc);
      if (mq.size() != 0) begin
        chk("rnd_out_pc", out_pc, mq[0].pc);
        chk("rnd_out_npc", out_npc, mq[0].npc);
        chk("rnd_out_inst", out_inst, mq[0].inst);
`ifdef FE_QUEUE_INST_COUNT_EN
        chk("rnd_out_count", out_count, mq[0].cnt);
`endif
      end
      de_ready = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc = 32'($urandom_range(0, 1023)) << 2;
      if ($urandom_range(0, 3) != 0) rand_bp = (mpc >= 32'hFFC) ? 32'h0 : mpc + 32'd4;
      else rand_bp = 32'($urandom_range(0, 1023)) << 2;
      @(posedge clk);
      if (redirect_valid) begin
        mq.delete();
        mpc = redirect_pc;
      end else begin
        mpop = (mq.size() != 0) && de_ready;
        mpush = (mq.size() < 4) || mpop;
        if (mpop) void'(mq.pop_front());
        if (mpush) begin
          e.inst = inst_of(mpc);
          e.pc = mpc;
          e.npc = rand_bp;
          e.cnt = mcnt;
          mq.push_back(e);
          mpc = rand_bp;
          mcnt = mcnt + 32'd1;
        end
      end
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
